// File: rtl/hba_gpio_irq.sv
// hba_gpio_irq: GPIO_WIDTH-pin HBA bus slave with per-pin edge-detect interrupts.
// Optional per-pin input debounce filter is built when HBA_GPIO_DEBOUNCE_EN is defined.
module hba_gpio_irq #(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int PERIPH_ADDR       = 0,
    parameter int GPIO_WIDTH        = 4
`ifdef HBA_GPIO_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES   = 16
`endif
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        hba_select,
    input  logic                                        hba_rnw,
    input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0]                       hba_dbus,
    output logic                                        hba_xferack,
    output logic [DBUS_WIDTH-1:0]                       hba_dbus_slave,
    output logic                                        hba_interrupt,
    output logic [GPIO_WIDTH-1:0]                       gpio_out_en,
    output logic [GPIO_WIDTH-1:0]                       gpio_out_sig,
    input  logic [GPIO_WIDTH-1:0]                       gpio_in_sig
);
    localparam int GW = GPIO_WIDTH;
    localparam int PW = PERIPH_ADDR_WIDTH;
    localparam int RW = REG_ADDR_WIDTH;

    localparam logic [PW-1:0] PERIPH_ID   = PW'(PERIPH_ADDR);
    localparam logic [RW-1:0] R_OUT       = RW'(0);
    localparam logic [RW-1:0] R_DIR       = RW'(1);
    localparam logic [RW-1:0] R_IN        = RW'(2);
    localparam logic [RW-1:0] R_INT_EN    = RW'(3);
    localparam logic [RW-1:0] R_STATUS    = RW'(4);
    localparam logic [RW-1:0] R_EDGE_SEL  = RW'(5);
    localparam logic [RW-1:0] R_EDGE_BOTH = RW'(6);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    state_t state_q, state_d;

    logic [GW-1:0] out_q, out_d;
    logic [GW-1:0] dir_q, dir_d;
    logic [GW-1:0] int_en_q, int_en_d;
    logic [GW-1:0] status_q, status_d;
    logic [GW-1:0] edge_sel_q, edge_sel_d;
    logic [GW-1:0] edge_both_q, edge_both_d;
    logic [GW-1:0] sync1_q, sync1_d;
    logic [GW-1:0] sync2_q, sync2_d;
    logic [GW-1:0] prev_q, prev_d;
    logic          irq_q, irq_d;

    logic [PW-1:0]         periph_f;
    logic [RW-1:0]         reg_f;
    logic [GW-1:0]         wdata;
    logic [GW-1:0]         filt;
    logic [GW-1:0]         rise, fall, evt, clr;
    logic                  wr_en;
    logic [DBUS_WIDTH-1:0] rd_word;

    assign periph_f = hba_abus[PW+RW-1:RW];
    assign reg_f    = hba_abus[RW-1:0];
    assign wdata    = hba_dbus[GW-1:0];

    generate
        if (DBUS_WIDTH > GW) begin : g_unused
            logic unused_dbus;
            assign unused_dbus = ^hba_dbus[DBUS_WIDTH-1:GW];
        end
    endgenerate

`ifdef HBA_GPIO_DEBOUNCE_EN
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [GW-1:0][CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0]         filt_q, filt_d;

    // Counter runs only while sync disagrees with the filtered level; any agreement restarts it.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < GW; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;
    assign evt  = (edge_both_q & (rise | fall))
                | (~edge_both_q & edge_sel_q & rise)
                | (~edge_both_q & ~edge_sel_q & fall);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hba_select && periph_f == PERIPH_ID) state_d = S_ACK;
            S_ACK:   state_d = S_WAIT;
            S_WAIT:  if (!hba_select) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en = (state_q == S_ACK) && !hba_rnw;
    assign clr   = (wr_en && reg_f == R_STATUS) ? wdata : '0;

    always_comb begin
        out_d       = out_q;
        dir_d       = dir_q;
        int_en_d    = int_en_q;
        edge_sel_d  = edge_sel_q;
        edge_both_d = edge_both_q;
        // New events win over a simultaneous W1C of the same bit.
        status_d    = (status_q & ~clr) | evt;
        sync1_d     = gpio_in_sig;
        sync2_d     = sync1_q;
        prev_d      = filt;
        irq_d       = |(status_q & int_en_q);
        if (wr_en) begin
            case (reg_f)
                R_OUT:       out_d       = wdata;
                R_DIR:       dir_d       = wdata;
                R_INT_EN:    int_en_d    = wdata;
                R_EDGE_SEL:  edge_sel_d  = wdata;
                R_EDGE_BOTH: edge_both_d = wdata;
                default:     ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (reg_f)
            R_OUT:       rd_word[GW-1:0] = out_q;
            R_DIR:       rd_word[GW-1:0] = dir_q;
            R_IN:        rd_word[GW-1:0] = filt;
            R_INT_EN:    rd_word[GW-1:0] = int_en_q;
            R_STATUS:    rd_word[GW-1:0] = status_q;
            R_EDGE_SEL:  rd_word[GW-1:0] = edge_sel_q;
            R_EDGE_BOTH: rd_word[GW-1:0] = edge_both_q;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            dir_q       <= '0;
            int_en_q    <= '0;
            status_q    <= '0;
            edge_sel_q  <= '0;
            edge_both_q <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            dir_q       <= dir_d;
            int_en_q    <= int_en_d;
            status_q    <= status_d;
            edge_sel_q  <= edge_sel_d;
            edge_both_q <= edge_both_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            irq_q       <= irq_d;
        end
    end

    // Ack and read data decode straight from state so a reset clears them at once.
    assign hba_xferack    = (state_q == S_ACK);
    assign hba_dbus_slave = (hba_xferack && hba_rnw) ? rd_word : '0;
    assign hba_interrupt  = irq_q;
    assign gpio_out_en    = dir_q;
    assign gpio_out_sig   = out_q;

endmodule

// File: tb/tb_hba_gpio_irq.sv
// Bench for hba_gpio_irq: directed vectors, behavioural register/pin model compared every cycle,
// plus hand-computed literal expectations. Debounce checks build only with HBA_GPIO_DEBOUNCE_EN.
module tb_hba_gpio_irq;
    localparam int GW = 4;
`ifdef HBA_GPIO_DEBOUNCE_EN
    localparam int DB  = 16;
    localparam int LAT = DB;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hba_select = 1'b0;
    logic        hba_rnw = 1'b0;
    logic [11:0] hba_abus = '0;
    logic [7:0]  hba_dbus = '0;
    logic        hba_xferack;
    logic [7:0]  hba_dbus_slave;
    logic        hba_interrupt;
    logic [3:0]  gpio_out_en, gpio_out_sig;
    logic [3:0]  gpio_in_sig = '0;

    always #5 clk = ~clk;

    hba_gpio_irq #(
        .DBUS_WIDTH(8), .PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8),
        .PERIPH_ADDR(1), .GPIO_WIDTH(GW)
`ifdef HBA_GPIO_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(DB)
`endif
    ) dut (
        .clk(clk), .reset(reset), .hba_select(hba_select), .hba_rnw(hba_rnw),
        .hba_abus(hba_abus), .hba_dbus(hba_dbus), .hba_xferack(hba_xferack),
        .hba_dbus_slave(hba_dbus_slave), .hba_interrupt(hba_interrupt),
        .gpio_out_en(gpio_out_en), .gpio_out_sig(gpio_out_sig), .gpio_in_sig(gpio_in_sig)
    );

    int n_chk = 0;
    int n_err = 0;
    logic done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register file, pad history and sticky event bits.
    logic [3:0] m_out, m_dir, m_inen, m_stat, m_esel, m_eboth;
    logic [3:0] smp0, smp1, fcur, fprev, evt, stat_n;
    logic       m_int;
    logic       wr_pend = 1'b0;
    logic [7:0] wr_reg = '0;
    logic [3:0] wr_dat = '0;
`ifdef HBA_GPIO_DEBOUNCE_EN
    int         run[GW];
    logic [3:0] lasts;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out <= '0; m_dir <= '0; m_inen <= '0; m_stat <= '0; m_esel <= '0; m_eboth <= '0;
            smp0 <= '0; smp1 <= '0; fcur <= '0; fprev <= '0; m_int <= 1'b0;
`ifdef HBA_GPIO_DEBOUNCE_EN
            for (int i = 0; i < GW; i++) run[i] = 0;
            lasts = '0;
`endif
        end else begin
            // A pin event is any change of the filtered level that the pin's edge config accepts.
            for (int i = 0; i < GW; i++)
                evt[i] = (fcur[i] != fprev[i]) && (m_eboth[i] || (m_esel[i] == fcur[i]));
            stat_n = m_stat | evt;
            if (wr_pend) begin
                case (wr_reg)
                    8'd0: m_out <= wr_dat;
                    8'd1: m_dir <= wr_dat;
                    8'd3: m_inen <= wr_dat;
                    8'd4: stat_n = (m_stat & ~wr_dat) | evt;
                    8'd5: m_esel <= wr_dat;
                    8'd6: m_eboth <= wr_dat;
                    default: ;
                endcase
            end
            m_stat <= stat_n;
            m_int  <= |(m_stat & m_inen);
            smp0   <= gpio_in_sig;
            smp1   <= smp0;
            fprev  <= fcur;
`ifdef HBA_GPIO_DEBOUNCE_EN
            for (int i = 0; i < GW; i++) begin
                if (smp1[i] == lasts[i]) run[i]++;
                else run[i] = 1;
                lasts[i] = smp1[i];
                if (smp1[i] != fcur[i] && run[i] >= DB) fcur[i] <= smp1[i];
            end
`else
            fcur <= smp0;
`endif
        end
    end

    function automatic logic [7:0] m_read(input logic [7:0] rg);
        case (rg)
            8'd0: return {4'h0, m_out};
            8'd1: return {4'h0, m_dir};
            8'd2: return {4'h0, fcur};
            8'd3: return {4'h0, m_inen};
            8'd4: return {4'h0, m_stat};
            8'd5: return {4'h0, m_esel};
            8'd6: return {4'h0, m_eboth};
            default: return 8'h00;
        endcase
    endfunction

    logic       exp_ack = 1'b0;
    logic       exp_rnw = 1'b0;
    logic [7:0] exp_rd = '0;

    always @(negedge clk) begin
        #3;
        if (!done) begin
            chk("cyc_out_sig", gpio_out_sig, m_out);
            chk("cyc_out_en", gpio_out_en, m_dir);
            chk("cyc_irq", hba_interrupt, m_int);
            chk("cyc_ack", hba_xferack, exp_ack);
            if (!exp_ack) chk("cyc_idle_dbus", hba_dbus_slave, 8'h00);
            else if (exp_rnw) chk("cyc_rd_dbus", hba_dbus_slave, exp_rd);
        end
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) nstep();
    endtask

    task automatic xfer(input logic rnw, input logic [3:0] per, input logic [7:0] rg,
                        input logic [7:0] wd, output logic [7:0] rd);
        hba_select = 1'b1; hba_rnw = rnw; hba_abus = {per, rg}; hba_dbus = wd;
        nstep();
        if (per == 4'd1) begin
            exp_ack = 1'b1; exp_rnw = rnw; exp_rd = m_read(rg);
            if (!rnw) begin wr_pend = 1'b1; wr_reg = rg; wr_dat = wd[3:0]; end
        end
        rd = hba_dbus_slave;
        nstep();
        exp_ack = 1'b0; wr_pend = 1'b0;
        hba_select = 1'b0;
        nstep();
    endtask

    task automatic wr(input logic [7:0] rg, input logic [7:0] d);
        logic [7:0] dummy;
        xfer(1'b0, 4'd1, rg, d, dummy);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] rg, input logic [7:0] exp);
        logic [7:0] v;
        xfer(1'b1, 4'd1, rg, 8'h00, v);
        chk(nm, v, exp);
    endtask

    initial begin
        int nack;
        nack = 0;
        repeat (3) nstep();
        chk("rst_ack", hba_xferack, 0);
        chk("rst_dbus", hba_dbus_slave, 0);
        chk("rst_irq", hba_interrupt, 0);
        chk("rst_out_en", gpio_out_en, 0);
        chk("rst_out_sig", gpio_out_sig, 0);
        reset = 1'b0;
        nstep();

        wr(8'd0, 8'h0A);
        wr(8'd1, 8'h0F);
        chk("out_sig", gpio_out_sig, 4'hA);
        chk("out_en", gpio_out_en, 4'hF);
        rd_chk("rd_out", 8'd0, 8'h0A);
        rd_chk("rd_dir", 8'd1, 8'h0F);
        wr(8'd0, 8'hFA);
        rd_chk("rd_out_upper", 8'd0, 8'h0A);
        wr(8'd9, 8'hFF);
        rd_chk("rd_unmapped", 8'd7, 8'h00);

        gpio_in_sig = 4'h5;
        rd_chk("in_latency", 8'd2, 8'h00);
        wait_n(LAT);
        rd_chk("in_val", 8'd2, 8'h05);

        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = {4'd2, 8'd2};
        repeat (10) begin
            nstep();
            if (hba_xferack) nack++;
        end
        chk("foreign_ack", nack, 0);
        hba_select = 1'b0;
        nstep();

        gpio_in_sig = 4'h0;
        wait_n(4 + LAT);
        wr(8'd4, 8'h0F);
        rd_chk("stat_clr", 8'd4, 8'h00);
        wr(8'd5, 8'h01);
        wr(8'd3, 8'h01);
        gpio_in_sig = 4'h1;
        wait_n(3 + LAT);
        chk("irq_before", hba_interrupt, 0);
        nstep();
        chk("irq_after", hba_interrupt, 1);
        rd_chk("stat_pin0", 8'd4, 8'h01);
        wr(8'd4, 8'h01);
        chk("irq_w1c", hba_interrupt, 0);

        wr(8'd6, 8'h02);
        gpio_in_sig = 4'h3; wait_n(5 + LAT);
        rd_chk("both_rise", 8'd4, 8'h02); wr(8'd4, 8'h02);
        gpio_in_sig = 4'h1; wait_n(5 + LAT);
        rd_chk("both_fall", 8'd4, 8'h02); wr(8'd4, 8'h02);
        gpio_in_sig = 4'h3; wait_n(5 + LAT);
        rd_chk("both_rise2", 8'd4, 8'h02); wr(8'd4, 8'h02);
        wr(8'd6, 8'h00);
        gpio_in_sig = 4'h1; wait_n(5 + LAT);
        rd_chk("fall_only_fall", 8'd4, 8'h02); wr(8'd4, 8'h02);
        gpio_in_sig = 4'h3; wait_n(5 + LAT);
        rd_chk("fall_only_rise", 8'd4, 8'h00);

        gpio_in_sig = 4'h2; wait_n(5 + LAT);
        rd_chk("pin0_fall_ignored", 8'd4, 8'h00);
        gpio_in_sig = 4'h3; wait_n(1 + LAT);
        wr(8'd4, 8'h01);
        rd_chk("set_wins", 8'd4, 8'h01);

        hba_select = 1'b1; hba_rnw = 1'b0; hba_abus = {4'd1, 8'd0}; hba_dbus = 8'h03;
        nstep();
        chk("ack_pre_reset", hba_xferack, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ack", hba_xferack, 0);
        chk("rst_mid_dbus", hba_dbus_slave, 0);
        chk("rst_mid_out_en", gpio_out_en, 0);
        chk("rst_mid_out_sig", gpio_out_sig, 0);
        chk("rst_mid_irq", hba_interrupt, 0);
        hba_select = 1'b0;
        wait_n(2);
        reset = 1'b0;
        nstep();
        rd_chk("rst_out", 8'd0, 8'h00);
        wait_n(4 + LAT);
        rd_chk("rst_stat", 8'd4, 8'h00);
        rd_chk("rst_in", 8'd2, 8'h03);

`ifdef HBA_GPIO_DEBOUNCE_EN
        wr(8'd5, 8'h04);
        gpio_in_sig = 4'h7; wait_n(10);
        gpio_in_sig = 4'h3; wait_n(25);
        rd_chk("glitch_in", 8'd2, 8'h03);
        rd_chk("glitch_stat", 8'd4, 8'h00);
        gpio_in_sig = 4'h7; wait_n(17);
        rd_chk("deb_in_edge18", 8'd2, 8'h07);
        rd_chk("deb_stat", 8'd4, 8'h04);
        gpio_in_sig = 4'h3; wait_n(16);
        rd_chk("deb_fall_hold", 8'd2, 8'h07);
`endif

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
